cache_controller: RTL
=====================

Name: cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller with single-word lines.
- Sits between the CPU load/store port and main_memory; it is main_memory's only requester.
- Serves hits locally in 2 cycles.
- On a miss it writes back a dirty victim, then fills from main_memory using main_memory's req/we/addr/wdata → ready/done/rdata handshake.

Parameters:
- ADDR_W, 16, word address width (matches main_memory ADDR_W).
- DATA_W, 32, data word width (matches main_memory DATA_W).
- INDEX_W, 6, index bits; 2**INDEX_W lines; TAG_W = ADDR_W-INDEX_W.
- CNT_W, 16, width of hit/miss statistics counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request; sampled only while cpu_ready=1.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_ready  out  1  controller idle, will accept cpu_req this cycle.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  load data, valid while cpu_done=1.
- mem_req  out  1  one-cycle request pulse to main_memory.
- mem_we  out  1  1=write-back, 0=fill.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write-back data.
- mem_ready  in  1  main_memory idle.
- mem_done  in  1  main_memory completion pulse.
- mem_rdata  in  DATA_W  fill data, valid with mem_done.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (async):
  - state=IDLE; all valid and dirty bits = 0; hit_count = miss_count = 0.
  - cpu_ready=1; cpu_done=0; cpu_rdata=0.
  - mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0.
  - Tag and data arrays are not reset.
- All outputs are registered.
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESPOND.
- IDLE:
  - cpu_ready=1.
  - cpu_req=1 at edge N → latch we/addr/wdata, go to LOOKUP; cpu_ready=0 from N+1.
- LOOKUP: hit = valid[idx] && tag[idx]==addr tag.
  - Hit, load → RESPOND with cpu_rdata=data[idx].
  - Hit, store → write data, set dirty, then RESPOND.
  - Either hit increments hit_count; cpu_done is high the cycle after LOOKUP, i.e. 2 cycles after acceptance.
  - Miss → increment miss_count.
    - Victim valid && dirty → WB_REQ.
    - Else store → install the line (valid=1, dirty=1, tag, data) → RESPOND. No memory traffic.
    - Else load → FILL_REQ.
- WB_REQ:
  - Wait for mem_ready=1, then pulse mem_req for exactly 1 cycle with mem_we=1, mem_addr={victim tag, idx}, mem_wdata=victim data.
  - → WB_WAIT.
- WB_WAIT:
  - Wait for mem_done, then clear dirty[idx].
  - Load → FILL_REQ. Store → install as above → RESPOND.
- FILL_REQ: wait for mem_ready, pulse mem_req with mem_we=0, mem_addr=latched addr → FILL_WAIT.
- FILL_WAIT:
  - On mem_done install valid=1, dirty=0, tag, data=mem_rdata.
  - Set cpu_rdata=mem_rdata → RESPOND.
- RESPOND: cpu_done=1 for one cycle → IDLE; cpu_ready=1 the following cycle.
- mem_req is never high for 2 consecutive cycles. At most one memory transaction is outstanding.
- mem_done outside WB_WAIT/FILL_WAIT is ignored.
- cpu_req while cpu_ready=0 is ignored; it is not queued.
- Counters saturate at 2**CNT_W-1. They never wrap.
- Reset mid-operation (any state):
  - Immediately returns to IDLE with all valid bits cleared.
  - The in-flight memory transaction is abandoned; main_memory shares rst.
- Index = addr[INDEX_W-1:0]; tag = addr[ADDR_W-1:INDEX_W].

Decomposition:
- cache_pkg holds:
  - state enum cache_state_t (7 states);
  - localparams TAG_W and LINES;
  - helper functions get_idx/get_tag.
- One sub-module, cache_line_array, holds the tag/data/valid/dirty storage:
  - 1 read port, 1 write port;
  - valid/dirty kept in flops cleared by rst.
- The top level holds the FSM, the request latches and the counters.

Test Plan:
- Pairing: main_memory is instantiated with LATENCY=8.
- Store miss, clean: after reset, store 0xA5A5A5A5 to 0x00C8 → no mem_req; cpu_done 2 cycles after accept; miss_count=1.
- Load hit: load 0x00C8 → cpu_done 2 cycles after accept, cpu_rdata=0xA5A5A5A5, no mem_req, hit_count=1.
- Dirty conflict miss: load 0x10C8 (same idx 8) → first mem_req with we=1, addr=0x00C8, wdata=0xA5A5A5A5; after its mem_done, second mem_req with we=0, addr=0x10C8; cpu_rdata equals memory word 0x10C8; miss_count=2.
- Write-back proof: load 0x00C8 → clean miss; single fill mem_req (we=0); cpu_rdata=0xA5A5A5A5.
- Reset during FILL_WAIT: assert rst 3 cycles after mem_req → cpu_ready=1, mem_req=0 and counters=0 immediately. A subsequent load 0x00C8 misses (mem_req issued).
- Busy/back-pressure: hold cpu_req=1 with a different addr during a miss, and hold mem_ready=0 for 5 cycles → no second acceptance until cpu_ready=1; mem_req delayed until mem_ready=1 and pulses exactly 1 cycle.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-back cache controller.
// Default geometry: 16-bit word addresses, 6 index bits, 10 tag bits.
package cache_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INDEX_W = 6;
  localparam int TAG_W       = DEF_ADDR_W - DEF_INDEX_W;
  localparam int LINES       = 2 ** DEF_INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_WAIT,
    FILL_REQ,
    FILL_WAIT,
    RESPOND
  } cache_state_t;

  function automatic logic [DEF_INDEX_W-1:0] get_idx(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_INDEX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [DEF_ADDR_W-1:0] addr);
    return addr[DEF_ADDR_W-1:DEF_INDEX_W];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/data/valid/dirty storage for the cache: one combinational read port,
// one synchronous write port. Only valid/dirty are cleared by reset.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int TAG_BITS = TAG_W,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_idx,
  input  logic                wr_valid,
  input  logic                wr_dirty,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [DATA_W-1:0]   wr_data
);

  localparam int N = 2 ** INDEX_W;

  logic [N-1:0]        valid_bits;
  logic [N-1:0]        dirty_bits;
  logic [TAG_BITS-1:0] tag_mem  [N];
  logic [DATA_W-1:0]   data_mem [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_idx] <= wr_valid;
      dirty_bits[wr_idx] <= wr_dirty;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_bits[rd_idx];
  assign rd_dirty = dirty_bits[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with single-word
// lines; FSM, request latches and saturating hit/miss counters live here.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINE_TAG_W = ADDR_W - INDEX_W;

  cache_state_t state_q, state_d;

  logic              req_we, req_we_d;
  logic [ADDR_W-1:0] req_addr, req_addr_d;
  logic [DATA_W-1:0] req_wdata, req_wdata_d;

  logic              cpu_ready_d, cpu_done_d;
  logic [DATA_W-1:0] cpu_rdata_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [CNT_W-1:0]  hit_count_d, miss_count_d;

  logic [INDEX_W-1:0]    idx;
  logic [LINE_TAG_W-1:0] req_tag;
  logic                  rd_valid, rd_dirty;
  logic [LINE_TAG_W-1:0] rd_tag;
  logic [DATA_W-1:0]     rd_data;
  logic                  wr_en, wr_valid, wr_dirty;
  logic [LINE_TAG_W-1:0] wr_tag;
  logic [DATA_W-1:0]     wr_data;
  logic                  hit;

  assign idx     = get_idx(req_addr);
  assign req_tag = get_tag(req_addr);
  assign hit     = rd_valid && (rd_tag == req_tag);

  cache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_BITS(LINE_TAG_W),
    .DATA_W  (DATA_W)
  ) u_lines (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_valid(wr_valid),
    .wr_dirty(wr_dirty),
    .wr_tag  (wr_tag),
    .wr_data (wr_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      cpu_ready  <= 1'b1;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_q    <= state_d;
      req_we     <= req_we_d;
      req_addr   <= req_addr_d;
      req_wdata  <= req_wdata_d;
      cpu_ready  <= cpu_ready_d;
      cpu_done   <= cpu_done_d;
      cpu_rdata  <= cpu_rdata_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      hit_count  <= hit_count_d;
      miss_count <= miss_count_d;
    end
  end

  // Outputs are computed one cycle early so every port comes straight from a
  // flop; mem_req defaults low so it can only ever pulse for a single cycle.
  always_comb begin
    state_d      = state_q;
    req_we_d     = req_we;
    req_addr_d   = req_addr;
    req_wdata_d  = req_wdata;
    cpu_ready_d  = cpu_ready;
    cpu_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    hit_count_d  = hit_count;
    miss_count_d = miss_count;
    wr_en        = 1'b0;
    wr_valid     = 1'b1;
    wr_dirty     = 1'b1;
    wr_tag       = req_tag;
    wr_data      = req_wdata;

    case (state_q)
      IDLE: begin
        cpu_ready_d = 1'b1;
        if (cpu_req && cpu_ready) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          cpu_ready_d = 1'b0;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (hit_count != {CNT_W{1'b1}}) hit_count_d = hit_count + 1'b1;
          if (req_we) wr_en = 1'b1;
          else cpu_rdata_d = rd_data;
          cpu_done_d = 1'b1;
          state_d    = RESPOND;
        end else begin
          if (miss_count != {CNT_W{1'b1}}) miss_count_d = miss_count + 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d = WB_REQ;
          end else if (req_we) begin
            wr_en      = 1'b1;
            cpu_done_d = 1'b1;
            state_d    = RESPOND;
          end else begin
            state_d = FILL_REQ;
          end
        end
      end
      WB_REQ: begin
        if (mem_ready) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {rd_tag, idx};
          mem_wdata_d = rd_data;
          state_d     = WB_WAIT;
        end
      end
      WB_WAIT: begin
        // A load rewrites the victim as clean; the fill replaces it shortly.
        if (mem_done) begin
          wr_en = 1'b1;
          if (req_we) begin
            cpu_done_d = 1'b1;
            state_d    = RESPOND;
          end else begin
            wr_dirty = 1'b0;
            wr_tag   = rd_tag;
            wr_data  = rd_data;
            state_d  = FILL_REQ;
          end
        end
      end
      FILL_REQ: begin
        if (mem_ready) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = req_addr;
          state_d    = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (mem_done) begin
          wr_en       = 1'b1;
          wr_dirty    = 1'b0;
          wr_data     = mem_rdata;
          cpu_rdata_d = mem_rdata;
          cpu_done_d  = 1'b1;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

endmodule
